pci_memtarget: RTL and testbench

PCI memory-space target controller for the card's 4 KB register/memory window. Decodes memory read and write transactions against the base address programmed through config space. Sequences each data phase onto a simple req/ack local bus. Drives DEVSEL#, TRDY#, STOP# and the AD output enable, including the initial-latency retry and end-of-window disconnect rules.

---
 rtl/pci_pkg.sv | 30 +++
 rtl/pci_lat_timer.sv | 34 +++
 rtl/pci_memtarget.sv | 189 ++++++++++++++++++
 tb/tb_pci_memtarget.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// PCI bus command codes and the memory-target state encoding.
package pci_pkg;

  localparam logic [3:0] PCI_MEMREAD   = 4'b0110;
  localparam logic [3:0] PCI_MEMWRITE  = 4'b0111;
  localparam logic [3:0] PCI_CFGREAD   = 4'b1010;
  localparam logic [3:0] PCI_CFGWRITE  = 4'b1011;
  localparam logic [3:0] PCI_MEMRDMULT = 4'b1100;
  localparam logic [3:0] PCI_MEMRDLINE = 4'b1110;
  localparam logic [3:0] PCI_MEMWRINV  = 4'b1111;

  typedef enum logic [2:0] {
    StIdle,
    StRdFetch,
    StRdXfer,
    StWrWait,
    StWrStore,
    StStopping,
    StTurn
  } tgt_state_e;

  function automatic logic is_mem_read(input logic [3:0] cmd);
    return (cmd == PCI_MEMREAD) || (cmd == PCI_MEMRDMULT) || (cmd == PCI_MEMRDLINE);
  endfunction

  function automatic logic is_mem_write(input logic [3:0] cmd);
    return (cmd == PCI_MEMWRITE) || (cmd == PCI_MEMWRINV);
  endfunction

endpackage

// File: rtl/pci_lat_timer.sv
// Initial-latency counter: runs from DEVSEL# assertion until the first data transfer.
module pci_lat_timer #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  logic [CntW-1:0] count_q;
  logic            running_q;

  assign expired = running_q && (count_q == CntW'(MAX_WAIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q <= 1'b0;
      count_q   <= '0;
    end else if (start) begin
      running_q <= 1'b1;
      count_q   <= '0;
    end else if (clear) begin
      running_q <= 1'b0;
      count_q   <= '0;
    end else if (running_q && !expired) begin
      count_q <= count_q + CntW'(1);
    end
  end

endmodule

// File: rtl/pci_memtarget.sv
// PCI memory-space target: decodes the 4 KB window and bridges data phases to a req/ack bus.
module pci_memtarget
  import pci_pkg::*;
#(
  parameter int unsigned WIN_BITS = 12,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                  pci_clk_i,
  input  logic                  pci_rst_ni,
  input  logic                  pci_frame_ni,
  input  logic                  pci_irdy_ni,
  input  logic [3:0]            pci_cbe_ni,
  input  logic [31:0]           pci_ad_i,
  output logic [31:0]           pci_ad_o,
  output logic                  pci_devsel_no,
  output logic                  pci_trdy_no,
  output logic                  pci_stop_no,
  output logic                  active_o,
  input  logic                  memen_i,
  input  logic [31-WIN_BITS:0]  base_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [WIN_BITS-3:0]   mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_data_o,
  input  logic [31:0]           mem_data_i,
  input  logic                  mem_ack_i
);

  localparam int unsigned AW = WIN_BITS - 2;

  tgt_state_e    state_q, state_d;
  logic          devsel_q, devsel_d, trdy_q, trdy_d, stop_q, stop_d, active_q, active_d;
  logic          req_q, req_d, we_q, we_d, rd_q, rd_d, last_q, last_d;
  logic [31:0]   ad_q, ad_d, data_q, data_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic          addr_ok, xfer, start, clear, expired;

  assign addr_ok = memen_i && (pci_ad_i[31:WIN_BITS] == base_i) && (pci_ad_i[1:0] == 2'b00);

  pci_lat_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_lat_timer (
    .clk    (pci_clk_i),
    .rst_n  (pci_rst_ni),
    .start  (start),
    .clear  (clear),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    ad_d    = ad_q;
    req_d   = req_q && !mem_ack_i;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    data_d  = data_q;
    rd_d    = rd_q;
    last_d  = last_q;
    start   = 1'b0;
    xfer    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!pci_frame_ni && addr_ok && is_mem_read(pci_cbe_ni)) begin
          start   = 1'b1;
          state_d = StRdFetch;
          req_d   = 1'b1;
          we_d    = 1'b0;
          be_d    = 4'hF;
          rd_d    = 1'b1;
          addr_d  = pci_ad_i[WIN_BITS-1:2];
        end else if (!pci_frame_ni && addr_ok && is_mem_write(pci_cbe_ni)) begin
          start   = 1'b1;
          state_d = StWrWait;
          we_d    = 1'b1;
          rd_d    = 1'b0;
          addr_d  = pci_ad_i[WIN_BITS-1:2];
        end
      end
      StRdFetch: begin
        // Expiry wins over a same-edge ack; that word is simply dropped.
        if (expired) begin
          state_d = StStopping;
        end else if (mem_ack_i) begin
          ad_d    = mem_data_i;
          state_d = StRdXfer;
        end
      end
      StRdXfer: begin
        if (!pci_irdy_ni) begin
          xfer = 1'b1;
          if (pci_frame_ni) begin
            state_d = StTurn;
          end else if (&addr_q) begin
            state_d = StStopping;
          end else begin
            addr_d  = addr_q + AW'(1);
            req_d   = 1'b1;
            state_d = StRdFetch;
          end
        end else if (expired) begin
          state_d = StStopping;
        end
      end
      StWrWait: begin
        if (!pci_irdy_ni) begin
          xfer    = 1'b1;
          data_d  = pci_ad_i;
          be_d    = ~pci_cbe_ni;
          req_d   = 1'b1;
          last_d  = pci_frame_ni;
          state_d = StWrStore;
        end else if (expired) begin
          state_d = StStopping;
        end
      end
      StWrStore: begin
        if (mem_ack_i) begin
          if (last_q) begin
            state_d = StTurn;
          end else if (&addr_q) begin
            state_d = StStopping;
          end else begin
            addr_d  = addr_q + AW'(1);
            state_d = StWrWait;
          end
        end
      end
      StStopping: begin
        if (pci_frame_ni && (!req_q || mem_ack_i)) state_d = StTurn;
      end
      StTurn:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    clear    = xfer || (state_d inside {StStopping, StTurn, StIdle});
    devsel_d = !(state_d inside {StRdFetch, StRdXfer, StWrWait, StWrStore, StStopping});
    trdy_d   = !(state_d inside {StRdXfer, StWrWait});
    stop_d   = (state_d != StStopping);
    // AD is driven one clock after the address phase to leave a turnaround cycle.
    active_d = rd_d && (state_q != StIdle) && (state_d inside {StRdFetch, StRdXfer, StStopping});
  end

  always_ff @(posedge pci_clk_i or negedge pci_rst_ni) begin
    if (!pci_rst_ni) begin
      state_q  <= StIdle;
      devsel_q <= 1'b1;
      trdy_q   <= 1'b1;
      stop_q   <= 1'b1;
      active_q <= 1'b0;
      ad_q     <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      data_q   <= '0;
      rd_q     <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      devsel_q <= devsel_d;
      trdy_q   <= trdy_d;
      stop_q   <= stop_d;
      active_q <= active_d;
      ad_q     <= ad_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      data_q   <= data_d;
      rd_q     <= rd_d;
      last_q   <= last_d;
    end
  end

  assign pci_ad_o      = ad_q;
  assign pci_devsel_no = devsel_q;
  assign pci_trdy_no   = trdy_q;
  assign pci_stop_no   = stop_q;
  assign active_o      = active_q;
  assign mem_req_o     = req_q;
  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_be_o      = be_q;
  assign mem_data_o    = data_q;

endmodule

// File: tb/tb_pci_memtarget.sv
// Bench for pci_memtarget: decode vector table, scoreboarded local bus, multi-cycle corner cases.
module tb_pci_memtarget;
  import pci_pkg::*;

  typedef struct {
    logic        memen;
    logic [19:0] base;
    logic [31:0] addr;
    logic [3:0]  cmd;
    logic        hit;
    logic        rd;
  } vec_t;

  typedef struct packed {
    logic [9:0]  addr;
    logic [3:0]  be;
    logic [31:0] data;
  } wr_t;

  logic        clk, rst_n, frame_n, irdy_n, devsel_n, trdy_n, stop_n, active;
  logic [3:0]  cbe, mem_be;
  logic [31:0] ad, ad_o, mem_data, mem_rdata;
  logic        memen, mem_req, mem_we, ack, hold_ack;
  logic [19:0] base;
  logic [9:0]  mem_addr;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_acks = 0;
  int          ack_delay = 1;
  logic [31:0] mem_model [1024];
  logic [31:0] last_rd;
  logic [31:0] rd_exp[$];
  wr_t         wr_exp[$];
  vec_t        vecs[12];

  pci_memtarget #(
    .WIN_BITS(12),
    .MAX_WAIT(16)
  ) dut (
    .pci_clk_i    (clk),
    .pci_rst_ni   (rst_n),
    .pci_frame_ni (frame_n),
    .pci_irdy_ni  (irdy_n),
    .pci_cbe_ni   (cbe),
    .pci_ad_i     (ad),
    .pci_ad_o     (ad_o),
    .pci_devsel_no(devsel_n),
    .pci_trdy_no  (trdy_n),
    .pci_stop_no  (stop_n),
    .active_o     (active),
    .memen_i      (memen),
    .base_i       (base),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_be_o     (mem_be),
    .mem_data_o   (mem_data),
    .mem_data_i   (mem_rdata),
    .mem_ack_i    (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Local-bus slave: acks each request after ack_delay clocks and scores writes.
  initial begin
    int wcnt;
    wr_t w;
    wcnt = 0;
    ack = 1'b0;
    mem_rdata = '0;
    forever begin
      tick();
      if (!rst_n) begin
        ack = 1'b0;
        wcnt = 0;
      end else if (ack) begin
        ack = 1'b0;
      end else if (mem_req && !hold_ack) begin
        if (wcnt >= ack_delay) begin
          wcnt = 0;
          ack = 1'b1;
          n_acks++;
          if (mem_we) begin
            check("wr_expected", 64'(wr_exp.size() != 0), 1);
            if (wr_exp.size() != 0) begin
              w = wr_exp.pop_front();
              check("wr_addr_be_data", {18'h0, mem_addr, mem_be, mem_data}, {18'h0, w});
            end
          end else begin
            mem_rdata = mem_model[mem_addr];
          end
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic addr_phase(input logic [31:0] a, input logic [3:0] cmd);
    frame_n = 1'b0;
    irdy_n = 1'b1;
    ad = a;
    cbe = cmd;
    tick();
  endtask

  task automatic wait_trdy(output logic got);
    int n = 0;
    while (trdy_n && stop_n && n < 40) begin
      tick();
      n++;
    end
    got = !trdy_n;
  endtask

  task automatic wait_release(input string name);
    int n = 0;
    while (!devsel_n && n < 60) begin
      tick();
      n++;
    end
    check({name, "_release"}, devsel_n, 1);
    check({name, "_turn_outs"}, {61'h0, trdy_n, stop_n, active}, 3'b110);
    tick();
  endtask

  task automatic wr_phase(input logic [31:0] d, input logic [9:0] wa, input logic last,
                          input string name);
    logic got;
    irdy_n = 1'b0;
    frame_n = last;
    ad = d;
    cbe = 4'h0;
    wr_exp.push_back('{wa, 4'hF, d});
    wait_trdy(got);
    check(name, got, 1);
    if (got) tick();
  endtask

  task automatic run_single(input vec_t v, input logic [31:0] wdata, input string name);
    logic bad, got;
    logic [9:0] wa;
    wa = v.addr[11:2];
    memen = v.memen;
    base = v.base;
    addr_phase(v.addr, v.cmd);
    check({name, "_devsel_k"}, devsel_n, !v.hit);
    check({name, "_req_k"}, mem_req, v.hit && v.rd);
    check({name, "_active_k"}, active, 0);
    if (v.hit && v.rd) check({name, "_addr_k"}, mem_addr, wa);
    frame_n = 1'b1;
    irdy_n = 1'b0;
    cbe = 4'h0;
    ad = wdata;
    if (!v.hit) begin
      bad = 1'b0;
      repeat (4) begin
        tick();
        if (!devsel_n || mem_req) bad = 1'b1;
      end
      check({name, "_miss_quiet"}, bad, 0);
      irdy_n = 1'b1;
      tick();
      return;
    end
    if (v.rd) begin
      rd_exp.push_back(mem_model[wa]);
      tick();
      check({name, "_active_k1"}, active, 1);
    end else begin
      wr_exp.push_back('{wa, 4'hF, wdata});
    end
    wait_trdy(got);
    check({name, "_trdy"}, got, 1);
    if (got) begin
      if (v.rd && rd_exp.size() != 0) begin
        last_rd = rd_exp.pop_front();
        check({name, "_rd_data"}, ad_o, last_rd);
      end
      tick();
      irdy_n = 1'b1;
      if (v.rd) check({name, "_trdy_one_clk"}, trdy_n, 1);
    end
    irdy_n = 1'b1;
    wait_release(name);
    check({name, "_wr_drained"}, wr_exp.size(), 0);
  endtask

  initial begin
    int acks0, stop_at;
    logic got;
    rst_n = 1'b0;
    frame_n = 1'b1;
    irdy_n = 1'b1;
    cbe = 4'h0;
    ad = '0;
    memen = 1'b1;
    base = 20'h000DE;
    hold_ack = 1'b0;
    last_rd = '0;
    for (int i = 0; i < 1024; i++) mem_model[i] = 32'h3C000000 ^ (i * 32'h00010001);
    mem_model[4] = 32'hCAFEF00D;

    vecs[0]  = '{1'b1, 20'h000DE, 32'h000DE010, PCI_MEMREAD,   1'b1, 1'b1};
    vecs[1]  = '{1'b0, 20'h000DE, 32'h000DE010, PCI_MEMREAD,   1'b0, 1'b1};
    vecs[2]  = '{1'b1, 20'h000DF, 32'h000DE010, PCI_MEMREAD,   1'b0, 1'b1};
    vecs[3]  = '{1'b1, 20'h000DE, 32'h000DE010, PCI_CFGREAD,   1'b0, 1'b1};
    vecs[4]  = '{1'b1, 20'h000DE, 32'h000DE011, PCI_MEMREAD,   1'b0, 1'b1};
    vecs[5]  = '{1'b1, 20'h000DE, 32'h000DE020, PCI_MEMRDMULT, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 20'h000DE, 32'h000DEFFC, PCI_MEMRDLINE, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 20'h000DE, 32'h000DE100, PCI_MEMWRITE,  1'b1, 1'b0};
    vecs[8]  = '{1'b1, 20'h000DE, 32'h000DE104, PCI_MEMWRINV,  1'b1, 1'b0};
    vecs[9]  = '{1'b1, 20'h000DE, 32'h000DE100, PCI_CFGWRITE,  1'b0, 1'b0};
    vecs[10] = '{1'b1, 20'h000DE, 32'h000DE010, 4'b0010,       1'b0, 1'b1};
    vecs[11] = '{1'b1, 20'h000DE, 32'h000DE102, PCI_MEMWRITE,  1'b0, 1'b0};

    repeat (2) tick();
    check("reset_pci", {60'h0, devsel_n, trdy_n, stop_n, active}, 4'b1110);
    check("reset_mem", {mem_req, mem_we, mem_addr, mem_be, mem_data}, '0);
    check("reset_ad", ad_o, 0);
    #2 rst_n = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 12; i++) begin
      ack_delay = (i == 0) ? 2 : 1;
      run_single(vecs[i], 32'h5A5A0000 | 32'(i), $sformatf("vec%0d", i));
    end

    // Three-word write burst from the window base.
    ack_delay = 0;
    memen = 1'b1;
    base = 20'h000DE;
    acks0 = n_acks;
    addr_phase(32'h000DE000, PCI_MEMWRITE);
    check("burst_devsel", devsel_n, 0);
    wr_phase(32'h11111111, 10'h000, 1'b0, "burst_w0");
    wr_phase(32'h22222222, 10'h001, 1'b0, "burst_w1");
    wr_phase(32'h33333333, 10'h002, 1'b1, "burst_w2");
    irdy_n = 1'b1;
    wait_release("burst");
    check("burst_drained", wr_exp.size(), 0);
    check("burst_acks", n_acks - acks0, 3);

    // Initial-latency retry with the local ack withheld.
    hold_ack = 1'b1;
    stop_at = 0;
    addr_phase(32'h000DE040, PCI_MEMREAD);
    frame_n = 1'b1;
    irdy_n = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (!stop_n && stop_at == 0) begin
        stop_at = n;
        check("retry_trdy_high", trdy_n, 1);
        check("retry_devsel_low", devsel_n, 0);
        irdy_n = 1'b1;
      end
    end
    check("retry_stop_clock", stop_at, 16);
    check("retry_req_held", mem_req, 1);
    hold_ack = 1'b0;
    irdy_n = 1'b1;
    wait_release("retry");
    check("retry_data_dropped", ad_o, last_rd);
    check("retry_idle", devsel_n, 1);

    // Window-end disconnect on a write burst from word 0x3FE.
    acks0 = n_acks;
    addr_phase(32'h000DEFF8, PCI_MEMWRITE);
    wr_phase(32'hA0A0A0A0, 10'h3FE, 1'b0, "wend_w0");
    wr_phase(32'hB1B1B1B1, 10'h3FF, 1'b0, "wend_w1");
    irdy_n = 1'b0;
    frame_n = 1'b0;
    ad = 32'hC2C2C2C2;
    wait_trdy(got);
    check("wend_no_third_xfer", got, 0);
    check("wend_stop", stop_n, 0);
    check("wend_no_req", mem_req, 0);
    frame_n = 1'b1;
    tick();
    irdy_n = 1'b1;
    wait_release("wend");
    check("wend_acks", n_acks - acks0, 2);
    check("wend_drained", wr_exp.size(), 0);

    // Asynchronous reset while a read fetch is outstanding.
    hold_ack = 1'b1;
    addr_phase(32'h000DE010, PCI_MEMREAD);
    frame_n = 1'b1;
    irdy_n = 1'b0;
    tick();
    check("rst_pre_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_pci", {60'h0, devsel_n, trdy_n, stop_n, active}, 4'b1110);
    check("rst_async_mem", {mem_req, mem_we, mem_addr, mem_be, mem_data}, '0);
    check("rst_async_ad", ad_o, 0);
    frame_n = 1'b1;
    irdy_n = 1'b1;
    hold_ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    ack_delay = 1;
    run_single(vecs[0], 32'h0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
